mem_sdp_clr: RTL and testbench



---
 rtl/mem_sdp_clr.sv | 149 ++++++++++++++
 tb/tb_mem_sdp_clr.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_sdp_clr.sv
// Simple-dual-port memory (one write port, one read port) with a hardware
// clear sequencer that zeroes every entry after reset or on request.
// Read latency is 1 or 2 cycles (RD_LAT); d_o_vld strobes when read data lands.
// Optional macro MEM_WR_BYPASS_EN: same-cycle same-address read returns the
// write data (write-first) instead of the old contents (read-first).
module mem_sdp_clr #(
  parameter int unsigned DW     = 8,
  parameter int unsigned AW     = 10,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  output logic          busy,
  input  logic          wr,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] d_i,
  input  logic          rd,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] d_o,
  output logic          d_o_vld
);

  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          rd_acc;
  logic [DW-1:0] rd_data;

  logic [DW-1:0] mem_q [DEPTH];

  logic          vld1_q;
  logic [DW-1:0] rdata1_q;

  // Next-state, sweep counter and array write-port selection
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = d_i;
    rd_acc    = 1'b0;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        cnt_d     = cnt_q + AW'(1);
        if (clr) begin
          cnt_d = '0;
        end else if (cnt_q == {AW{1'b1}}) begin
          state_d = RUN;
        end
      end
      RUN: begin
        rd_acc = rd;
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (wr) begin
          mem_we = 1'b1;
        end
      end
      default: ;
    endcase
    busy_d = (state_d == CLEAR);
  end

  // FSM state, sweep counter and busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Storage array; contents are zeroed by the sweep, not by reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

`ifdef MEM_WR_BYPASS_EN
  // Write-first: a live port write to the read address forwards d_i
  assign rd_data = (state_q == RUN && wr && !clr && wr_addr == rd_addr) ? d_i : mem_q[rd_addr];
`else
  // Read-first: old contents are returned on a collision
  assign rd_data = mem_q[rd_addr];
`endif

  // First read stage: array read register, holds when no read is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld1_q   <= 1'b0;
      rdata1_q <= '0;
    end else begin
      vld1_q <= rd_acc;
      if (rd_acc) begin
        rdata1_q <= rd_data;
      end
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic          vld2_q;
      logic [DW-1:0] rdata2_q;

      // Extra output register stage for two-cycle latency
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld2_q   <= 1'b0;
          rdata2_q <= '0;
        end else begin
          vld2_q <= vld1_q;
          if (vld1_q) begin
            rdata2_q <= rdata1_q;
          end
        end
      end

      assign d_o     = rdata2_q;
      assign d_o_vld = vld2_q;
    end else begin : g_lat1
      assign d_o     = rdata1_q;
      assign d_o_vld = vld1_q;
    end
  endgenerate

  assign busy = busy_q;

endmodule

// File: tb/tb_mem_sdp_clr.sv
// Scoreboard bench for mem_sdp_clr: a driver issues directed and random
// traffic while updating an array model; a negedge monitor pops expected
// read results and checks data, latency and hold behaviour.
module tb_mem_sdp_clr;

  parameter int unsigned RD_LAT = 1;
  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 1 << AW;
`ifdef MEM_WR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          clr;
  logic          busy;
  logic          wr;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] d_i;
  logic          rd;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] d_o;
  logic          d_o_vld;

  mem_sdp_clr #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .busy    (busy),
    .wr      (wr),
    .wr_addr (wr_addr),
    .d_i     (d_i),
    .rd      (rd),
    .rd_addr (rd_addr),
    .d_o     (d_o),
    .d_o_vld (d_o_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] m_mem [DEPTH];
  int            m_left;
  logic [DW-1:0] last_exp;
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
  endtask

  // One clock of stimulus; the model decides what the DUT must do with it
  task automatic step(input logic i_wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic i_rd, input logic [AW-1:0] ra, input logic i_clr);
    exp_t e;
    wr = i_wr; wr_addr = wa; d_i = wd; rd = i_rd; rd_addr = ra; clr = i_clr;
    if (m_left > 0) begin
      if (i_clr) m_left = DEPTH;
      else m_left--;
    end else begin
      if (i_rd) begin
        e.data = (BYP && i_wr && !i_clr && wa == ra) ? wd : m_mem[ra];
        e.due  = cyc + int'(RD_LAT);
        exp_q.push_back(e);
      end
      if (i_clr) begin
        m_left = DEPTH;
        model_clear();
      end else if (i_wr) begin
        m_mem[wa] = wd;
      end
    end
    @(posedge clk);
    #1;
    check("busy", 64'(busy), 64'(m_left > 0));
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic junk();
    step(1'($urandom), AW'($urandom), DW'($urandom), 1'($urandom), AW'($urandom), 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wr = 1'b0; rd = 1'b0; clr = 1'b0;
    #1;
    check("rst_d_o", 64'(d_o), 64'(0));
    check("rst_vld", 64'(d_o_vld), 64'(0));
    check("rst_busy", 64'(busy), 64'(1));
    exp_q.delete();
    m_left   = DEPTH;
    last_exp = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: checks every completed read and d_o hold between reads
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (d_o_vld) begin
        if (exp_q.size() == 0) begin
          check("unexpected_vld", 64'(d_o_vld), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("rd_data", 64'(d_o), 64'(e.data));
          check("rd_latency", 64'(cyc), 64'(e.due));
          last_exp = e.data;
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        check("missing_vld", 64'(d_o_vld), 64'(1));
      end else begin
        check("d_o_hold", 64'(d_o), 64'(last_exp));
      end
    end
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; wr = 1'b0; rd = 1'b0;
    wr_addr = '0; rd_addr = '0; d_i = '0;
    m_left = DEPTH; last_exp = '0;
    model_clear();
    @(posedge clk); #1;
    do_reset();

    // Sweep from reset with ignored port activity, then read blank entries
    repeat (DEPTH) junk();
    step(1'b0, '0, '0, 1'b1, AW'(0), 1'b0);
    step(1'b0, '0, '0, 1'b1, AW'(511), 1'b0);
    step(1'b0, '0, '0, 1'b1, AW'(1023), 1'b0);
    repeat (3) idle();

    // Boundary addresses
    step(1'b1, AW'(10'h3FF), 8'hA5, 1'b0, '0, 1'b0);
    step(1'b1, AW'(10'h000), 8'h5A, 1'b0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b1, AW'(10'h3FF), 1'b0);
    step(1'b0, '0, '0, 1'b1, AW'(10'h000), 1'b0);
    repeat (3) idle();

    // Back-to-back reads
    step(1'b1, AW'(1), 8'h11, 1'b0, '0, 1'b0);
    step(1'b1, AW'(2), 8'h22, 1'b0, '0, 1'b0);
    step(1'b1, AW'(3), 8'h33, 1'b0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b1, AW'(1), 1'b0);
    step(1'b0, '0, '0, 1'b1, AW'(2), 1'b0);
    step(1'b0, '0, '0, 1'b1, AW'(3), 1'b0);
    repeat (3) idle();

    // Same-address collision
    step(1'b1, AW'(7), 8'h10, 1'b0, '0, 1'b0);
    step(1'b1, AW'(7), 8'h20, 1'b1, AW'(7), 1'b0);
    step(1'b0, '0, '0, 1'b1, AW'(7), 1'b0);
    repeat (3) idle();

    // clr with an in-flight read and a dropped same-cycle write
    step(1'b1, AW'(4), 8'h44, 1'b0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b1, AW'(4), 1'b0);
    step(1'b1, AW'(5), 8'h99, 1'b1, AW'(5), 1'b1);
    repeat (DEPTH - 1) junk();
    step(1'b0, '0, '0, 1'b1, AW'(4), 1'b0);
    step(1'b0, '0, '0, 1'b1, AW'(5), 1'b0);
    repeat (3) idle();

    // clr restart in the middle of a sweep, then reset mid-sweep
    step(1'b1, AW'(9), 8'h77, 1'b0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b0, '0, 1'b1);
    repeat (100) junk();
    step(1'b0, '0, '0, 1'b0, '0, 1'b1);
    repeat (299) junk();
    do_reset();
    repeat (DEPTH) junk();
    step(1'b0, '0, '0, 1'b1, AW'(9), 1'b0);
    step(1'b0, '0, '0, 1'b1, AW'($urandom), 1'b0);
    repeat (3) idle();

    // Random traffic on a narrow address window to provoke collisions
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom),
           1'($urandom), AW'($urandom_range(0, 15)), ($urandom_range(0, 999) == 0));
    end
    repeat (RD_LAT + 3) idle();
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
